// File: rtl/video_timing_driver.sv
// video_timing_driver: raster counters decoded into HDMI sync/enable and one-cycle-early pixel requests.
module video_timing_driver #(
  parameter logic [10:0] H_SYNC = 11'd40,
  parameter logic [10:0] H_BACK = 11'd220,
  parameter logic [10:0] H_DISP = 11'd1280,
  parameter logic [10:0] H_FRONT = 11'd110,
  parameter logic [10:0] V_SYNC = 11'd5,
  parameter logic [10:0] V_BACK = 11'd20,
  parameter logic [10:0] V_DISP = 11'd720,
  parameter logic [10:0] V_FRONT = 11'd5,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        data_req,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [23:0] video_rgb,
  output logic        frame_start
);
  localparam logic [10:0] H_SB = H_SYNC + H_BACK;
  localparam logic [10:0] H_SBD = H_SB + H_DISP;
  localparam logic [10:0] H_TOTAL = H_SBD + H_FRONT;
  localparam logic [10:0] H_REQ = H_SB - 11'd1;
  localparam logic [10:0] V_SB = V_SYNC + V_BACK;
  localparam logic [10:0] V_SBD = V_SB + V_DISP;
  localparam logic [10:0] V_TOTAL = V_SBD + V_FRONT;
  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_BACK = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_FRONT = 2'd3;

  logic [10:0] h_cnt, v_cnt;
  logic [1:0] h_st, v_st;
  logic h_end;

  always_ff @(posedge pixel_clk)
    if (sys_rst) begin
      h_cnt <= 11'd0;
      v_cnt <= 11'd0;
    end else begin
      h_cnt <= h_end ? 11'd0 : h_cnt + 11'd1;
      if (h_end) v_cnt <= (v_cnt == V_TOTAL - 11'd1) ? 11'd0 : v_cnt + 11'd1;
    end

  // Requests lead video_de by one cycle to cover the display block's output register.
  always_comb begin
    h_end = h_cnt == H_TOTAL - 11'd1;
    h_st = h_cnt < H_SYNC ? ST_SYNC : h_cnt < H_SB ? ST_BACK : h_cnt < H_SBD ? ST_ACTIVE : ST_FRONT;
    v_st = v_cnt < V_SYNC ? ST_SYNC : v_cnt < V_SB ? ST_BACK : v_cnt < V_SBD ? ST_ACTIVE : ST_FRONT;
    video_hs = (!sys_rst && h_st == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
    video_vs = (!sys_rst && v_st == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
    video_de = !sys_rst && h_st == ST_ACTIVE && v_st == ST_ACTIVE;
    data_req = !sys_rst && v_st == ST_ACTIVE && h_cnt >= H_REQ && h_cnt < H_SBD - 11'd1;
    pixel_xpos = data_req ? h_cnt - H_REQ : 11'd0;
    pixel_ypos = data_req ? v_cnt - V_SB : 11'd0;
    video_rgb = video_de ? pixel_data : 24'd0;
    frame_start = !sys_rst && h_cnt == 11'd0 && v_cnt == 11'd0;
  end
endmodule

// File: tb/tb_video_timing_driver.sv
// tb_video_timing_driver: directed checks on a small-raster instance and a default 720p instance.
module tb_video_timing_driver;
  logic pixel_clk = 1'b0;
  logic sys_rst = 1'b1;
  int checks = 0;
  int failures = 0;

  logic [23:0] s_pd;
  logic [10:0] s_xpos, s_ypos;
  logic s_req, s_hs, s_vs, s_de, s_fs;
  logic [23:0] s_rgb;

  logic [23:0] d_pd;
  logic [10:0] d_xpos, d_ypos;
  logic d_req, d_hs, d_vs, d_de, d_fs;
  logic [23:0] d_rgb;

  always #5 pixel_clk = ~pixel_clk;

  video_timing_driver #(
    .H_SYNC(11'd2), .H_BACK(11'd3), .H_DISP(11'd8), .H_FRONT(11'd2),
    .V_SYNC(11'd1), .V_BACK(11'd2), .V_DISP(11'd4), .V_FRONT(11'd1), .SYNC_POL(1'b1)
  ) u_small (
    .pixel_clk(pixel_clk), .sys_rst(sys_rst), .pixel_data(s_pd),
    .pixel_xpos(s_xpos), .pixel_ypos(s_ypos), .data_req(s_req),
    .video_hs(s_hs), .video_vs(s_vs), .video_de(s_de), .video_rgb(s_rgb), .frame_start(s_fs)
  );

  video_timing_driver u_dflt (
    .pixel_clk(pixel_clk), .sys_rst(sys_rst), .pixel_data(d_pd),
    .pixel_xpos(d_xpos), .pixel_ypos(d_ypos), .data_req(d_req),
    .video_hs(d_hs), .video_vs(d_vs), .video_de(d_de), .video_rgb(d_rgb), .frame_start(d_fs)
  );

  // Stand-in for the display block: registered echo of the requested X.
  always @(posedge pixel_clk) s_pd <= {13'd0, s_xpos};
  assign d_pd = 24'hFFFFFF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_s_hs"}, 32'(s_hs), 0);
    check({tag, "_s_vs"}, 32'(s_vs), 0);
    check({tag, "_s_de"}, 32'(s_de), 0);
    check({tag, "_s_req"}, 32'(s_req), 0);
    check({tag, "_s_fs"}, 32'(s_fs), 0);
    check({tag, "_s_xpos"}, 32'(s_xpos), 0);
    check({tag, "_s_ypos"}, 32'(s_ypos), 0);
    check({tag, "_s_rgb"}, 32'(s_rgb), 0);
    check({tag, "_d_hs"}, 32'(d_hs), 0);
    check({tag, "_d_vs"}, 32'(d_vs), 0);
    check({tag, "_d_de"}, 32'(d_de), 0);
    check({tag, "_d_rgb"}, 32'(d_rgb), 0);
  endtask

  initial begin
    int n, h, v, dl, dh;
    bit vact, e_de, e_req;
    int d_hs_l0, d_vs_cnt, d_de_pre, d_de_l25, d_req_l25, d_fs_cnt, d_blank_bad, d_first_de, d_ypos_l25;
    d_hs_l0 = 0; d_vs_cnt = 0; d_de_pre = 0; d_de_l25 = 0; d_req_l25 = 0;
    d_fs_cnt = 0; d_blank_bad = 0; d_first_de = -1; d_ypos_l25 = 0;
    repeat (5) begin
      step();
      check_idle("rst");
    end
    sys_rst = 1'b0;
    #0;
    check("rel_s_fs", 32'(s_fs), 1);
    check("rel_s_hs", 32'(s_hs), 1);
    check("rel_s_vs", 32'(s_vs), 1);
    check("rel_d_fs", 32'(d_fs), 1);
    check("rel_d_hs", 32'(d_hs), 1);
    check("rel_d_vs", 32'(d_vs), 1);
    for (n = 0; n < 26 * 1650; n++) begin
      if (n < 240) begin
        h = n % 15;
        v = (n % 120) / 15;
        vact = v >= 3 && v < 7;
        e_de = vact && h >= 5 && h < 13;
        e_req = vact && h >= 4 && h < 12;
        check("s_hs", 32'(s_hs), 32'(h < 2));
        check("s_vs", 32'(s_vs), 32'(v < 1));
        check("s_de", 32'(s_de), 32'(e_de));
        check("s_req", 32'(s_req), 32'(e_req));
        check("s_xpos", 32'(s_xpos), e_req ? h - 4 : 0);
        check("s_ypos", 32'(s_ypos), e_req ? v - 3 : 0);
        check("s_rgb", s_rgb, e_de ? h - 5 : 0);
        check("s_fs", 32'(s_fs), 32'(n % 120 == 0));
      end
      dl = n / 1650;
      dh = n % 1650;
      if (dl == 0 && d_hs) d_hs_l0++;
      if (d_vs) d_vs_cnt++;
      if (dl < 25 && d_de) d_de_pre++;
      if (dl == 25 && d_de) d_de_l25++;
      if (dl == 25 && d_req) d_req_l25++;
      if (dl == 25 && d_ypos != 0) d_ypos_l25++;
      if (d_fs) d_fs_cnt++;
      if (d_rgb !== (d_de ? 24'hFFFFFF : 24'd0)) d_blank_bad++;
      if (d_de && d_first_de < 0) d_first_de = n;
      if (dl == 25 && dh == 259) check("d_xpos_first", 32'(d_xpos), 0);
      if (dl == 25 && dh == 1538) check("d_xpos_last", 32'(d_xpos), 1279);
      if (dl == 25 && dh == 1539) check("d_last_req", 32'(d_req), 0);
      if (dl == 25 && dh == 1539) check("d_last_de", 32'(d_de), 1);
      step();
    end
    check("d_hs_line0", d_hs_l0, 40);
    check("d_vs_cycles", d_vs_cnt, 8250);
    check("d_de_blank_lines", d_de_pre, 0);
    check("d_de_line25", d_de_l25, 1280);
    check("d_req_line25", d_req_l25, 1280);
    check("d_ypos_line25", d_ypos_l25, 0);
    check("d_fs_count", d_fs_cnt, 1);
    check("d_blanking", d_blank_bad, 0);
    check("d_first_de", d_first_de, 25 * 1650 + 260);
    while (n % 120 != 66) begin
      step();
      n++;
    end
    check("pre_s_de", 32'(s_de), 1);
    check("pre_s_xpos", 32'(s_xpos), 2);
    check("pre_s_ypos", 32'(s_ypos), 1);
    sys_rst = 1'b1;
    #0;
    check_idle("mid");
    step();
    sys_rst = 1'b0;
    #0;
    check("restart_s_fs", 32'(s_fs), 1);
    check("restart_s_hs", 32'(s_hs), 1);
    check("restart_s_vs", 32'(s_vs), 1);
    check("restart_s_de", 32'(s_de), 0);
    check("restart_d_fs", 32'(d_fs), 1);
    repeat (2) step();
    check("restart_h2_hs", 32'(s_hs), 0);
    check("restart_h2_fs", 32'(s_fs), 0);
    repeat (13) step();
    check("restart_l1_hs", 32'(s_hs), 1);
    check("restart_l1_vs", 32'(s_vs), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
